// File: rtl/mem_pkg.sv
// Shared encodings for the load/store memory stage: access sizes, WB exception codes,
// handshake FSM states and the alignment rule.
package mem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [1:0] EXC_NONE     = 2'd0;
   localparam logic [1:0] EXC_MISALIGN = 2'd1;
   localparam logic [1:0] EXC_BUS      = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   // Reserved size 3 falls into the word rule; lane_bits is log2 of bytes per word.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [7:0] addr_lo,
                                          input int         lane_bits);
      logic [7:0] word_mask;
      word_mask = 8'((16'd1 << lane_bits) - 16'd1);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return addr_lo[0];
         default: return (addr_lo & word_mask) != 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store-data replication, byte enables, and
// load-lane extraction with sign or zero extension.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [$clog2(XLEN/8)-1:0] addr_lo,
   input  logic [1:0]                size,
   input  logic                      uns,
   input  logic [XLEN-1:0]           store_data,
   input  logic [XLEN-1:0]           read_data,
   output logic [XLEN-1:0]           write_data,
   output logic [XLEN/8-1:0]         byte_en,
   output logic [XLEN-1:0]           load_data
);

   localparam int NB  = XLEN / 8;
   localparam int ALB = $clog2(NB);

   logic [XLEN-1:0] shifted_s;
   logic            ext_bit_s;

   // Store-side replication and the lane mask shared by loads and stores
   always_comb begin
      write_data = {XLEN{1'b0}};
      byte_en    = {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
         case (size)
            SZ_B: begin
               write_data[8*i +: 8] = store_data[7:0];
               byte_en[i]           = (ALB'(i) == addr_lo);
            end
            SZ_H: begin
               write_data[8*i +: 8] = store_data[8*(i%2) +: 8];
               byte_en[i]           = ((ALB'(i) >> 1) == (addr_lo >> 1));
            end
            default: begin
               write_data[8*i +: 8] = store_data[8*i +: 8];
               byte_en[i]           = 1'b1;
            end
         endcase
      end
   end

   // Load-side: bring the addressed lane to bit 0, then fill the upper bits
   always_comb begin
      shifted_s = read_data >> {addr_lo, 3'b000};
      ext_bit_s = 1'b0;
      load_data = read_data;
      case (size)
         SZ_B: begin
            ext_bit_s       = shifted_s[7] & ~uns;
            load_data       = {XLEN{ext_bit_s}};
            load_data[7:0]  = shifted_s[7:0];
         end
         SZ_H: begin
            ext_bit_s       = shifted_s[15] & ~uns;
            load_data       = {XLEN{ext_bit_s}};
            load_data[15:0] = shifted_s[15:0];
         end
         default: begin
            ext_bit_s = 1'b0;
            load_data = read_data;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: drives the data-memory handshake, stalls upstream while waiting,
// flags misaligned and timed-out accesses, and registers results into WB.
module mem_stage_ls
   import mem_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15,
   parameter int RWIDTH  = 5
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_MEM,
   input  logic [XLEN-1:0]     ALU_out_MEM,
   input  logic [XLEN-1:0]     S3_MEM,
   input  logic                d_write_enable_MEM,
   input  logic                d_load_enable_MEM,
   input  logic [1:0]          size_MEM,
   input  logic                unsigned_MEM,
   input  logic [RWIDTH-1:0]   Rd_MEM,
   output logic [XLEN-1:0]     d_address,
   output logic [XLEN-1:0]     d_data_write,
   output logic [XLEN/8-1:0]   d_byte_en,
   output logic                d_write_enable,
   output logic                d_read_enable,
   input  logic [XLEN-1:0]     d_data_read,
   input  logic                d_data_valid,
   output logic                stall_MEM,
   output logic [XLEN-1:0]     ALU_out_MEM_backward,
   output logic [RWIDTH-1:0]   Rd_MEM_backward,
   output logic                valid_WB,
   output logic                d_load_enable_WB,
   output logic [RWIDTH-1:0]   Rd_WB,
   output logic [XLEN-1:0]     ALU_out_WB,
   output logic [XLEN-1:0]     load_data_WB,
   output logic [1:0]          exc_WB
);

   localparam int NB      = XLEN / 8;
   localparam int ALB     = $clog2(NB);
   localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   mem_state_e        state_r;
   mem_state_e        state_nxt_s;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_nxt_s;

   logic              acc_s;
   logic              is_load_s;
   logic              is_store_s;
   logic              misalign_s;
   logic              go_s;
   logic              timeout_hit_s;
   logic              strobe_s;
   logic              stall_s;
   logic [1:0]        exc_s;
   logic [XLEN-1:0]   wdata_s;
   logic [NB-1:0]     be_s;
   logic [XLEN-1:0]   ldata_s;

   // Load wins when both request bits are set
   assign is_load_s     = d_load_enable_MEM;
   assign is_store_s    = d_write_enable_MEM & ~d_load_enable_MEM;
   assign acc_s         = valid_MEM & (d_load_enable_MEM | d_write_enable_MEM);
   assign misalign_s    = is_misaligned(size_MEM, ALU_out_MEM[7:0], ALB);
   assign go_s          = acc_s & ~misalign_s;
   assign timeout_hit_s = (TIMEOUT > 0) && (state_r == ST_WAIT) && (cnt_r == CW'(TO_LAST));

   // Strobes drop in the timeout cycle so a late d_data_valid cannot complete anything
   assign strobe_s  = ~reset & go_s & ~timeout_hit_s;
   assign stall_s   = strobe_s & ~d_data_valid;

   mem_lane_align #(.XLEN(XLEN)) u_lane_align (
      .addr_lo    (ALU_out_MEM[ALB-1:0]),
      .size       (size_MEM),
      .uns        (unsigned_MEM),
      .store_data (S3_MEM),
      .read_data  (d_data_read),
      .write_data (wdata_s),
      .byte_en    (be_s),
      .load_data  (ldata_s)
   );

   assign d_address      = {ALU_out_MEM[XLEN-1:ALB], {ALB{1'b0}}};
   assign d_data_write   = wdata_s;
   assign d_byte_en      = strobe_s ? be_s : {NB{1'b0}};
   assign d_read_enable  = strobe_s & is_load_s;
   assign d_write_enable = strobe_s & is_store_s;
   assign stall_MEM      = stall_s;

   assign ALU_out_MEM_backward = ALU_out_MEM;
   assign Rd_MEM_backward      = (valid_MEM & ~d_load_enable_MEM) ? Rd_MEM : {RWIDTH{1'b0}};

   // Exception code carried into WB with the completing access
   always_comb begin
      exc_s = EXC_NONE;
      if (acc_s && misalign_s) begin
         exc_s = EXC_MISALIGN;
      end else if (timeout_hit_s) begin
         exc_s = EXC_BUS;
      end else begin
         exc_s = EXC_NONE;
      end
   end

   // Handshake FSM next state and wait counter
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = {CW{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (go_s && !d_data_valid) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (timeout_hit_s || d_data_valid || !go_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT;
               cnt_nxt_s   = cnt_r + CW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // WB register: bubble while stalled, capture the completing access otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_WB         <= 1'b0;
         d_load_enable_WB <= 1'b0;
         Rd_WB            <= {RWIDTH{1'b0}};
         ALU_out_WB       <= {XLEN{1'b0}};
         load_data_WB     <= {XLEN{1'b0}};
         exc_WB           <= EXC_NONE;
      end else if (stall_s) begin
         valid_WB <= 1'b0;
      end else begin
         valid_WB         <= valid_MEM;
         d_load_enable_WB <= valid_MEM & is_load_s & (exc_s == EXC_NONE);
         Rd_WB            <= Rd_MEM;
         ALU_out_WB       <= ALU_out_MEM;
         load_data_WB     <= ldata_s;
         exc_WB           <= exc_s;
      end
   end

endmodule
